// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
// Register indices, the hard-wired zero register and the controller state encoding.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    OPS,
    WAIT_RES,
    WRITE,
    ERR
  } rfc_state_t;

endpackage

// File: rtl/rf_rd_chan.sv
// One regfile read channel: issues the request, captures data on ack and tracks completion.
// A port that is not needed (unused or x0) completes immediately with a zero operand.
module rf_rd_chan
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            need,
  input  logic            abort,
  input  reg_addr_t       addr,
  output reg_addr_t       rd_addr,
  output logic            rd_addr_valid,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rd_data_ack,
  output logic [XLEN-1:0] op,
  output logic            fin
);

  logic done;

  // Completion is visible in the ack cycle itself so both ports can finish together.
  assign fin = done | (rd_addr_valid & rd_data_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr       <= REG_ZERO;
      rd_addr_valid <= 1'b0;
      done          <= 1'b0;
      op            <= '0;
    end else if (start) begin
      rd_addr       <= addr;
      rd_addr_valid <= need;
      done          <= !need;
      if (!need) op <= '0;
    end else if (abort) begin
      rd_addr_valid <= 1'b0;
    end else if (rd_addr_valid && rd_data_ack) begin
      op            <= rd_data;
      rd_addr_valid <= 1'b0;
      done          <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: fetches rs1/rs2, hands operands downstream,
// collects the result and writes it back to rd, with x0 semantics and an ack timeout.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  reg_addr_t       issue_rs1,
  input  reg_addr_t       issue_rs2,
  input  reg_addr_t       issue_rd,
  input  logic            issue_use_rs1,
  input  logic            issue_use_rs2,
  input  logic            issue_use_rd,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [XLEN-1:0] res_data,
  output reg_addr_t       rd_addr_a,
  output reg_addr_t       rd_addr_b,
  output logic            rd_addr_a_valid,
  output logic            rd_addr_b_valid,
  input  logic [XLEN-1:0] rd_data_a,
  input  logic [XLEN-1:0] rd_data_b,
  input  logic            rd_data_a_ack,
  input  logic            rd_data_b_ack,
  output reg_addr_t       wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            wr_data_valid,
  input  logic            wr_ack,
  output logic            err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  rfc_state_t      state, state_n;
  logic [TW-1:0]   timer, timer_n;
  reg_addr_t       rd_lat;
  logic            use_rd_lat;
  logic            start, abort, fin_a, fin_b;
  logic            op_valid_n, res_ready_n, wr_data_valid_n, err_n;
  reg_addr_t       wr_addr_n;
  logic [XLEN-1:0] wr_data_n;

  // Stale acks from a just-dropped request must clear before a new one is accepted.
  assign issue_ready = (state == IDLE) && !(rd_data_a_ack || rd_data_b_ack || wr_ack);
  assign start       = issue_valid && issue_ready;

  rf_rd_chan #(.XLEN(XLEN)) u_chan_a (
    .clk(clk), .reset(reset), .start(start),
    .need(issue_use_rs1 && (issue_rs1 != REG_ZERO)), .abort(abort),
    .addr(issue_rs1), .rd_addr(rd_addr_a), .rd_addr_valid(rd_addr_a_valid),
    .rd_data(rd_data_a), .rd_data_ack(rd_data_a_ack), .op(op_a), .fin(fin_a)
  );

  rf_rd_chan #(.XLEN(XLEN)) u_chan_b (
    .clk(clk), .reset(reset), .start(start),
    .need(issue_use_rs2 && (issue_rs2 != REG_ZERO)), .abort(abort),
    .addr(issue_rs2), .rd_addr(rd_addr_b), .rd_addr_valid(rd_addr_b_valid),
    .rd_data(rd_data_b), .rd_data_ack(rd_data_b_ack), .op(op_b), .fin(fin_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      op_valid      <= 1'b0;
      res_ready     <= 1'b0;
      wr_data_valid <= 1'b0;
      wr_addr       <= REG_ZERO;
      wr_data       <= '0;
      err           <= 1'b0;
      rd_lat        <= REG_ZERO;
      use_rd_lat    <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      op_valid      <= op_valid_n;
      res_ready     <= res_ready_n;
      wr_data_valid <= wr_data_valid_n;
      wr_addr       <= wr_addr_n;
      wr_data       <= wr_data_n;
      err           <= err_n;
      if (start) begin
        rd_lat     <= issue_rd;
        use_rd_lat <= issue_use_rd;
      end
    end
  end

  always_comb begin
    state_n         = state;
    timer_n         = timer;
    op_valid_n      = op_valid;
    res_ready_n     = res_ready;
    wr_data_valid_n = wr_data_valid;
    wr_addr_n       = wr_addr;
    wr_data_n       = wr_data;
    err_n           = err;
    abort           = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          timer_n = '0;
        end
      end
      READ: begin
        if (fin_a && fin_b) begin
          state_n    = OPS;
          op_valid_n = 1'b1;
        end else if (timer == TMO_LAST) begin
          abort   = 1'b1;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      OPS: begin
        if (op_ready) begin
          op_valid_n  = 1'b0;
          res_ready_n = 1'b1;
          state_n     = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          res_ready_n = 1'b0;
          if (use_rd_lat && (rd_lat != REG_ZERO)) begin
            wr_addr_n       = rd_lat;
            wr_data_n       = res_data;
            wr_data_valid_n = 1'b1;
            timer_n         = '0;
            state_n         = WRITE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WRITE: begin
        if (wr_ack) begin
          wr_data_valid_n = 1'b0;
          state_n         = IDLE;
        end else if (timer == TMO_LAST) begin
          wr_data_valid_n = 1'b0;
          err_n           = 1'b1;
          state_n         = ERR;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ERR: state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural regfile that follows the ack contract.
module tb_regfile_access_ctrl;
  import regfile_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            issue_valid = 1'b0;
  logic            issue_ready;
  reg_addr_t       issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic            issue_use_rs1 = 1'b0, issue_use_rs2 = 1'b0, issue_use_rd = 1'b0;
  logic            op_valid;
  logic            op_ready = 1'b0;
  logic [XLEN-1:0] op_a, op_b;
  logic            res_valid = 1'b0;
  logic            res_ready;
  logic [XLEN-1:0] res_data = '0;
  reg_addr_t       rd_addr_a, rd_addr_b;
  logic            rd_addr_a_valid, rd_addr_b_valid;
  logic [XLEN-1:0] rd_data_a = '0, rd_data_b = '0;
  logic            rd_data_a_ack = 1'b0, rd_data_b_ack = 1'b0;
  reg_addr_t       wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_data_valid;
  logic            wr_ack = 1'b0;
  logic            err;

  regfile_access_ctrl #(.XLEN(XLEN), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_use_rd(issue_use_rd),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_addr_a_valid(rd_addr_a_valid), .rd_addr_b_valid(rd_addr_b_valid),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_data_a_ack(rd_data_a_ack), .rd_data_b_ack(rd_data_b_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_ack(wr_ack), .err(err)
  );

  always #5 clk = ~clk;

  // Regfile model: ack follows valid by one cycle; x0 is deliberately non-zero.
  logic [XLEN-1:0] regs [32];
  logic            hold_b = 1'b0;
  logic            wr_prev = 1'b0;
  int              wr_count = 0;
  int              a_valid_cycles = 0;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[0] = 32'd43;
    regs[1] = 32'd42;
    regs[3] = 32'd47;
    regs[4] = 32'd43;
  end

  always @(posedge clk) begin
    rd_data_a_ack <= rd_addr_a_valid;
    rd_data_b_ack <= rd_addr_b_valid && !hold_b;
    rd_data_a     <= regs[rd_addr_a];
    rd_data_b     <= regs[rd_addr_b];
    wr_ack        <= wr_data_valid;
    wr_prev       <= wr_data_valid;
    if (wr_data_valid) regs[wr_addr] <= wr_data;
    if (wr_data_valid && !wr_prev) wr_count <= wr_count + 1;
    if (rd_addr_a_valid) a_valid_cycles <= a_valid_cycles + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for issue_ready, then presents one instruction for a single cycle.
  task automatic issue(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                       input logic u1, input logic u2, input logic ud);
    for (int n = 0; n < 20 && !issue_ready; n++) tick();
    chk("issue_ready", issue_ready, 1);
    issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
    issue_use_rs1 = u1; issue_use_rs2 = u2; issue_use_rd = ud;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic take_ops();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic give_res(input logic [XLEN-1:0] d);
    res_valid = 1'b1;
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    int c;
    int wc;
    int av;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_err", err, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_rd_valids", {rd_addr_a_valid, rd_addr_b_valid}, 0);
    chk("rst_wr_valid", wr_data_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_issue_ready", issue_ready, 1);

    // Two real reads: valids in cycle 1, op_valid in cycle 3.
    issue(5'd1, 5'd3, 5'd0, 1, 1, 0);
    chk("t1_valids_c1", {rd_addr_a_valid, rd_addr_b_valid}, 2'b11);
    chk("t1_addr_a", rd_addr_a, 1);
    chk("t1_addr_b", rd_addr_b, 3);
    tick();
    chk("t1_op_valid_c2", op_valid, 0);
    tick();
    chk("t1_op_valid_c3", op_valid, 1);
    chk("t1_op_a", op_a, 42);
    chk("t1_op_b", op_b, 47);
    tick();
    chk("t1_op_hold", {op_valid, op_a}, {1'b1, 32'd42});
    take_ops();
    chk("t1_op_drop", op_valid, 0);
    chk("t1_res_ready", res_ready, 1);
    give_res(32'h11);
    chk("t1_res_drop", res_ready, 0);
    chk("t1_no_write", wr_data_valid, 0);

    // rs1 = x0 must not touch the regfile even though the model's x0 is non-zero.
    av = a_valid_cycles;
    issue(5'd0, 5'd4, 5'd0, 1, 1, 0);
    chk("t2_valids_c1", {rd_addr_a_valid, rd_addr_b_valid}, 2'b01);
    tick();
    tick();
    chk("t2_op_valid_c3", op_valid, 1);
    chk("t2_op_a", op_a, 0);
    chk("t2_op_b", op_b, 43);
    chk("t2_no_a_read", a_valid_cycles - av, 0);
    take_ops();
    give_res(32'h22);

    // Full round trip with writeback to x5, then read it back.
    wc = wr_count;
    issue(5'd1, 5'd3, 5'd5, 1, 1, 1);
    for (int n = 0; n < 10 && !op_valid; n++) tick();
    chk("t3_op_valid", op_valid, 1);
    take_ops();
    give_res(32'hDEADBEEF);
    chk("t3_wr_valid", wr_data_valid, 1);
    chk("t3_wr_addr", wr_addr, 5);
    chk("t3_wr_data", wr_data, 32'hDEADBEEF);
    tick();
    chk("t3_wr_hold_ack", {wr_data_valid, wr_ack}, 2'b11);
    tick();
    chk("t3_wr_drop", wr_data_valid, 0);
    chk("t3_stale_ack_block", issue_ready, 0);
    tick();
    chk("t3_ready_after_stale", issue_ready, 1);
    chk("t3_one_write", wr_count - wc, 1);
    chk("t3_model_x5", regs[5], 32'hDEADBEEF);
    issue(5'd5, 5'd0, 5'd0, 1, 1, 0);
    tick();
    tick();
    chk("t3_rb_op_valid", op_valid, 1);
    chk("t3_rb_op_a", op_a, 32'hDEADBEEF);
    chk("t3_rb_op_b", op_b, 0);
    take_ops();
    give_res(32'h33);

    // No reads needed: op_valid in cycle 2; write to x0 is dropped.
    wc = wr_count;
    issue(5'd0, 5'd7, 5'd0, 1, 0, 1);
    chk("t4_no_valids", {rd_addr_a_valid, rd_addr_b_valid}, 0);
    tick();
    chk("t4_op_valid_c2", op_valid, 1);
    chk("t4_ops_zero", {op_a, op_b}, 64'd0);
    take_ops();
    give_res(32'h1234);
    chk("t4_no_wr_valid", wr_data_valid, 0);
    chk("t4_idle_next", issue_ready, 1);
    tick();
    chk("t4_no_write", wr_count - wc, 0);
    chk("t4_model_x0", regs[0], 43);

    // Withheld b ack: err rises in cycle 17 after issue.
    hold_b = 1'b1;
    issue(5'd1, 5'd3, 5'd0, 1, 1, 0);
    c = 1;
    while (c < 40 && !err) begin
      tick();
      c++;
    end
    chk("t5_err_cycle", c, 17);
    chk("t5_err", err, 1);
    chk("t5_valids_off", {rd_addr_a_valid, rd_addr_b_valid}, 0);
    chk("t5_no_op_valid", op_valid, 0);
    repeat (3) tick();
    chk("t5_err_sticky", {err, issue_ready}, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hold_b = 1'b0;
    chk("t5_err_cleared", err, 0);

    // Reset mid-READ drops requests the next cycle.
    issue(5'd1, 5'd3, 5'd0, 1, 1, 0);
    chk("t6_valids_c1", {rd_addr_a_valid, rd_addr_b_valid}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valids_dropped", {rd_addr_a_valid, rd_addr_b_valid}, 0);
    chk("t6_stale_block", issue_ready, 0);
    tick();
    chk("t6_ready", issue_ready, 1);
    chk("t6_op_valid", op_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
